mdr_load_sequencer: RTL and testbench
=====================================

Name: mdr_load_sequencer

Overview:
- Memory-read sequencer plus memory data register (MDR) for the multicycle datapath.
- Sits directly upstream of the load-size selector. Takes a load request from the control unit and runs a req/ack read to data memory.
- Latches the returned word, lane-shifted so the requested byte or half occupies the low bits. Drives the result on memory_data_register_out for the size selector to zero-extend.
- Flags ack timeouts and, optionally, misaligned accesses.

Parameters:
- TIMEOUT_CYCLES, 16, max cycles in REQ waiting for mem_ack before aborting; legal range 1..255.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- load_start  input  1  request from control unit; sampled only in IDLE.
- load_addr  input  32  byte address of the load.
- load_size  input  2  00 byte, 01 half, 10 word, 11 reserved (treated as word); same encoding as set_load_size_control.
- mem_rd_req  output  1  read request to data memory.
- mem_addr  output  32  word-aligned address {addr_q[31:2],2'b00}.
- mem_ack  input  1  memory has valid mem_rdata this cycle.
- mem_rdata  input  32  memory read data.
- memory_data_register_out  output  32  MDR contents, lane-shifted.
- load_busy  output  1  high in REQ and DONE.
- load_done  output  1  one-cycle pulse on successful capture.
- load_error  output  1  sticky error flag; cleared on next accepted load_start.

Behaviour:
- Reset (async, immediate): state IDLE; mem_rd_req=0, load_busy=0, load_done=0, load_error=0; mem_addr=0, memory_data_register_out=0; timeout counter=0.
- All outputs are registered or decoded from registered state; no combinational path from inputs to outputs.
- FSM states: IDLE, REQ, DONE, ERR.
- IDLE:
  - load_start=1 at an edge: capture addr_q, size_q; clear load_error and counter; go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - mem_rd_req=1 and mem_addr stable throughout.
  - mem_ack=1 at an edge: MDR <= mem_rdata >> (8*addr_q[1:0]) for byte and half, with zero fill; MDR <= mem_rdata unshifted for word and reserved. Then go to DONE.
  - No ack: counter increments. If counter reaches TIMEOUT_CYCLES-1 without ack, go to ERR.
  - Ack in the same cycle the timeout is reached: ack wins, capture proceeds.
- DONE: load_done=1 and mem_rd_req=0 for exactly one cycle; then IDLE.
- ERR: load_error<=1; mem_rd_req=0; MDR unchanged; next cycle IDLE. load_error stays high in IDLE until the next accepted load_start.
- Latency: load_start sampled at edge N, mem_rd_req high from N to N+1, ack at edge N+1 gives load_done high from N+1 to N+2. Minimum is 2 cycles from start to done pulse.
- load_start while busy (REQ, DONE, ERR): ignored, no queuing.
- load_start held high continuously: a new load is accepted on the first IDLE edge after DONE or ERR.
- mem_ack outside REQ: ignored.
- MDR holds its value until the next successful capture; it is unaffected by errors or reset-free idle time.
- Reset mid-REQ: mem_rd_req drops asynchronously; any in-flight ack after reset deasserts is ignored.

Optional Feature:
- Macro: MDR_ALIGN_CHECK_EN.
- Defined:
  - At load_start, half with addr[0]=1, or word/reserved with addr[1:0]!=0, is misaligned.
  - A misaligned load goes IDLE -> ERR directly; mem_rd_req is never asserted; load_error=1.
- Undefined:
  - No check is made.
  - Half uses shift 8*{addr[1],1'b0}, ignoring addr[0]; word ignores addr[1:0].
  - All loads issue a memory request.

Test Plan:
- Byte load: addr=0x00000103, size=00, ack 1 cycle after req with mem_rdata=0xAABBCCDD -> mem_addr=0x00000100; MDR=0x000000AA; load_done pulses once; latency 2 cycles.
- Half load: addr=0x00000102, size=01, ack after 3 wait cycles, rdata=0x12345678 -> MDR=0x00001234; mem_rd_req high 4 cycles; load_error=0.
- Timeout: TIMEOUT_CYCLES=4, word load, mem_ack held 0 -> mem_rd_req drops after 4 REQ cycles; load_error=1 and sticky; MDR keeps previous value 0x00001234. Next load_start clears load_error.
- Ack exactly on the last timeout cycle, rdata=0xCAFEBABE, word, addr=0x40 -> load_done=1, load_error=0, MDR=0xCAFEBABE.
- Async reset asserted mid-REQ -> mem_rd_req=0 before the next clock edge; all outputs 0. A late mem_ack after reset deasserts -> no load_done.
- With MDR_ALIGN_CHECK_EN: word at 0x00000006 -> load_error=1 and no mem_rd_req. Without the macro, same request -> req to 0x00000004; MDR = rdata unshifted.

Source files
------------

// File: rtl/mdr_load_sequencer.sv
// rtl/mdr_load_sequencer.sv - memory read sequencer and lane-shifting memory data register
// Optional feature: define MDR_ALIGN_CHECK_EN to reject misaligned half/word loads.
module mdr_load_sequencer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_start,
    input  logic [31:0] load_addr,
    input  logic [1:0]  load_size,
    output logic        mem_rd_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] memory_data_register_out,
    output logic        load_busy,
    output logic        load_done,
    output logic        load_error
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT_CYCLES - 1);

    state_t      state, state_nxt;
    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic [7:0]  cnt;
    logic [31:0] mdr;
    logic        err_q;
    logic        misaligned;
    logic [4:0]  shamt;
    logic [31:0] captured;

`ifdef MDR_ALIGN_CHECK_EN
    always_comb begin
        misaligned = 1'b0;
        case (load_size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = load_addr[0];
            default: misaligned = |load_addr[1:0];
        endcase
    end
`else
    assign misaligned = 1'b0;
`endif

    // Move the addressed byte/half into the low bits; words pass through untouched.
    always_comb begin
        shamt = 5'd0;
        case (size_q)
            2'b00:   shamt = {addr_q[1:0], 3'b000};
            2'b01:   shamt = {addr_q[1], 4'b0000};
            default: shamt = 5'd0;
        endcase
        captured = mem_rdata >> shamt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (load_start) state_nxt = misaligned ? ERR : REQ;
            end
            REQ: begin
                if (mem_ack)                 state_nxt = DONE;
                else if (cnt == LAST_WAIT)   state_nxt = ERR;
            end
            DONE:    state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            addr_q <= 32'd0;
            size_q <= 2'd0;
            cnt    <= 8'd0;
            mdr    <= 32'd0;
            err_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (load_start) begin
                        addr_q <= load_addr;
                        size_q <= load_size;
                        cnt    <= 8'd0;
                        err_q  <= misaligned;
                    end
                end
                REQ: begin
                    // An ack on the final wait cycle still counts as a successful capture.
                    if (mem_ack)                 mdr   <= captured;
                    else if (cnt == LAST_WAIT)   err_q <= 1'b1;
                    else                         cnt   <= cnt + 8'd1;
                end
                default: ;
            endcase
        end
    end

    assign mem_rd_req               = (state == REQ);
    assign mem_addr                 = {addr_q[31:2], 2'b00};
    assign memory_data_register_out = mdr;
    assign load_busy                = (state == REQ) || (state == DONE);
    assign load_done                = (state == DONE);
    assign load_error               = err_q;

endmodule

// File: tb/tb_mdr_load_sequencer.sv
// tb/tb_mdr_load_sequencer.sv - directed and randomized checks of mdr_load_sequencer
module tb_mdr_load_sequencer;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_start = 1'b0;
    logic [31:0] load_addr = 32'd0;
    logic [1:0]  load_size = 2'd0;
    logic        mem_rd_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic [31:0] memory_data_register_out;
    logic        load_busy;
    logic        load_done;
    logic        load_error;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_mdr = 32'd0;

    mdr_load_sequencer #(.TIMEOUT_CYCLES(T)) dut (
        .clk                      (clk),
        .reset                    (reset),
        .load_start               (load_start),
        .load_addr                (load_addr),
        .load_size                (load_size),
        .mem_rd_req               (mem_rd_req),
        .mem_addr                 (mem_addr),
        .mem_ack                  (mem_ack),
        .mem_rdata                (mem_rdata),
        .memory_data_register_out (memory_data_register_out),
        .load_busy                (load_busy),
        .load_done                (load_done),
        .load_error               (load_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic bit is_misaligned(input logic [31:0] a, input logic [1:0] s);
`ifdef MDR_ALIGN_CHECK_EN
        if (s == 2'd1) return (a % 2) != 0;
        if (s >= 2'd2) return (a % 4) != 0;
        return 1'b0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] lane_value(input logic [31:0] a, input logic [1:0] s,
                                               input logic [31:0] d);
        int byte_off;
        byte_off = int'(a % 4);
        if (s == 2'd0) return d >> (8 * byte_off);
        if (s == 2'd1) return d >> (8 * ((byte_off / 2) * 2));
        return d;
    endfunction

    // ack_delay = number of REQ cycles without ack before the ack cycle
    task automatic run_load(input string tag, input logic [31:0] a, input logic [1:0] s,
                            input logic [31:0] d, input int ack_delay);
        bit ok, misal;
        int exp_reqs, reqs;
        misal    = is_misaligned(a, s);
        ok       = !misal && (ack_delay < T);
        exp_reqs = misal ? 0 : (ok ? ack_delay + 1 : T);

        @(negedge clk);
        load_start = 1'b1; load_addr = a; load_size = s;
        @(negedge clk);
        load_start = 1'b0;
        reqs = 0;
        for (int c = 0; c < 300; c++) begin
            if (!mem_rd_req) break;
            reqs++;
            check({tag, ".mem_addr"}, mem_addr, {a[31:2], 2'b00});
            check({tag, ".busy_req"}, {31'd0, load_busy}, 32'd1);
            if (c == 0) check({tag, ".err_clr"}, {31'd0, load_error}, 32'd0);
            mem_ack   = (c == ack_delay);
            mem_rdata = mem_ack ? d : $urandom;
            @(negedge clk);
            mem_ack = 1'b0;
        end
        check({tag, ".req_cycles"}, reqs, exp_reqs);
        check({tag, ".done"}, {31'd0, load_done}, {31'd0, ok});
        if (ok) exp_mdr = lane_value(a, s, d);
        @(negedge clk);
        check({tag, ".done_idle"}, {31'd0, load_done}, 32'd0);
        check({tag, ".busy_idle"}, {31'd0, load_busy}, 32'd0);
        check({tag, ".error"}, {31'd0, load_error}, {31'd0, !ok});
        check({tag, ".mdr"}, memory_data_register_out, exp_mdr);
    endtask

    initial begin
        #1;
        check("rst.req", {31'd0, mem_rd_req}, 32'd0);
        check("rst.addr", mem_addr, 32'd0);
        check("rst.mdr", memory_data_register_out, 32'd0);
        check("rst.flags", {29'd0, load_busy, load_done, load_error}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run_load("byte", 32'h0000_0103, 2'd0, 32'hAABB_CCDD, 0);
        run_load("half", 32'h0000_0102, 2'd1, 32'h1234_5678, 3);
        run_load("tmo", 32'h0000_0000, 2'd2, 32'h5555_5555, 99);
        repeat (3) @(negedge clk);
        check("tmo.sticky", {31'd0, load_error}, 32'd1);
        check("tmo.mdr_kept", memory_data_register_out, 32'h0000_1234);
        run_load("lastack", 32'h0000_0040, 2'd2, 32'hCAFE_BABE, T - 1);
        run_load("word6", 32'h0000_0006, 2'd2, 32'h89AB_CDEF, 1);

        for (int i = 0; i < 24; i++) begin
            logic [31:0] ra, rd;
            logic [1:0]  rs;
            ra = $urandom; rs = 2'($urandom_range(0, 3)); rd = $urandom;
            run_load($sformatf("rnd%0d", i), ra, rs, rd, int'($urandom_range(0, T + 1)));
        end

        // ack while idle must not produce a capture
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        mem_ack = 1'b0;
        check("idle_ack.done", {31'd0, load_done}, 32'd0);
        check("idle_ack.mdr", memory_data_register_out, exp_mdr);

        // asynchronous reset in the middle of a request
        @(negedge clk);
        load_start = 1'b1; load_addr = 32'h0000_0200; load_size = 2'd2;
        @(negedge clk);
        load_start = 1'b0;
        check("mid.req", {31'd0, mem_rd_req}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("mid.req_drop", {31'd0, mem_rd_req}, 32'd0);
        check("mid.addr", mem_addr, 32'd0);
        check("mid.mdr", memory_data_register_out, 32'd0);
        check("mid.flags", {29'd0, load_busy, load_done, load_error}, 32'd0);
        exp_mdr = 32'd0;
        @(negedge clk);
        reset = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
        @(negedge clk);
        mem_ack = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check("late_ack.done", {31'd0, load_done}, 32'd0);
            @(negedge clk);
        end
        check("late_ack.mdr", memory_data_register_out, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
